// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: 4-direction player movement with map-ROM collision probe and step pacing.
// Optional edge wrap-around with PLAYER_WRAP_EN (clamp at edges otherwise). Rev 1.0
`default_nettype none

module player_motion_ctrl #(
   parameter int          X_W        = 10,
   parameter int          Y_W        = 10,
   parameter int          X_MAX      = 639,
   parameter int          Y_MAX      = 479,
   parameter int          X_INIT     = 0,
   parameter int          Y_INIT     = 0,
   parameter int          STEP       = 1,
   parameter int          STEP_TICKS = 1000000,
   parameter int          MAP_SHIFT  = 2,
   parameter int          MAP_XAW    = 8,
   parameter int          MAP_YAW    = 6,
   parameter int          MAP_LAT    = 1,
   parameter logic [11:0] WALL_RGB   = 12'h000,
   parameter logic [3:0]  KEY_RIGHT  = 4'hD,
   parameter logic [3:0]  KEY_LEFT   = 4'hA,
   parameter logic [3:0]  KEY_DOWN   = 4'h5,
   parameter logic [3:0]  KEY_UP     = 4'hE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [3:0]                 key,
   input  logic [11:0]                map_pixel,
   output logic [MAP_XAW+MAP_YAW-1:0] map_adr,
   output logic [X_W-1:0]             player_xpos,
   output logic [Y_W-1:0]             player_ypos,
   output logic                       moving,
   output logic                       blocked
);

   localparam int TMR_W  = $clog2(STEP_TICKS + 1);
   localparam int WCNT_W = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;

   localparam logic [X_W:0] X_MAX_E   = (X_W+1)'(X_MAX);
   localparam logic [X_W:0] X_RANGE_E = (X_W+1)'(X_MAX + 1);
   localparam logic [X_W:0] X_STEP_E  = (X_W+1)'(STEP);
   localparam logic [Y_W:0] Y_MAX_E   = (Y_W+1)'(Y_MAX);
   localparam logic [Y_W:0] Y_RANGE_E = (Y_W+1)'(Y_MAX + 1);
   localparam logic [Y_W:0] Y_STEP_E  = (Y_W+1)'(STEP);

   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(STEP_TICKS - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAP_LAT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [X_W-1:0]             tgt_x, tgt_x_nxt;
   logic [Y_W-1:0]             tgt_y, tgt_y_nxt;
   logic [X_W-1:0]             xpos_nxt;
   logic [Y_W-1:0]             ypos_nxt;
   logic [MAP_XAW+MAP_YAW-1:0] adr_nxt;
   logic                       blocked_nxt;
   logic [TMR_W-1:0]           timer, timer_nxt;
   logic [WCNT_W-1:0]          wcnt, wcnt_nxt;

   logic [X_W:0]               x_inc, x_dec, x_right, x_left;
   logic [Y_W:0]               y_inc, y_dec, y_down, y_up;
   logic [X_W-1:0]             cand_x, sh_x;
   logic [Y_W-1:0]             cand_y, sh_y;
   logic                       key_dir;

   // Edge handling on the one-bit-wider sums; the MSB of the difference flags underflow.
   always_comb begin
      x_inc = {1'b0, player_xpos} + X_STEP_E;
      x_dec = {1'b0, player_xpos} - X_STEP_E;
      y_inc = {1'b0, player_ypos} + Y_STEP_E;
      y_dec = {1'b0, player_ypos} - Y_STEP_E;
`ifdef PLAYER_WRAP_EN
      x_right = (x_inc > X_MAX_E) ? (x_inc - X_RANGE_E) : x_inc;
      x_left  = x_dec[X_W] ? (x_dec + X_RANGE_E) : x_dec;
      y_down  = (y_inc > Y_MAX_E) ? (y_inc - Y_RANGE_E) : y_inc;
      y_up    = y_dec[Y_W] ? (y_dec + Y_RANGE_E) : y_dec;
`else
      x_right = (x_inc > X_MAX_E) ? X_MAX_E : x_inc;
      x_left  = x_dec[X_W] ? '0 : x_dec;
      y_down  = (y_inc > Y_MAX_E) ? Y_MAX_E : y_inc;
      y_up    = y_dec[Y_W] ? '0 : y_dec;
`endif
   end

   always_comb begin
      cand_x  = player_xpos;
      cand_y  = player_ypos;
      key_dir = 1'b1;
      case (key)
         KEY_RIGHT: cand_x = X_W'(x_right);
         KEY_LEFT:  cand_x = X_W'(x_left);
         KEY_DOWN:  cand_y = Y_W'(y_down);
         KEY_UP:    cand_y = Y_W'(y_up);
         default:   key_dir = 1'b0;
      endcase
      sh_x = cand_x >> MAP_SHIFT;
      sh_y = cand_y >> MAP_SHIFT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The CHECK cycle counts as the first hold tick, so a held key repeats
   // every STEP_TICKS+MAP_LAT+1 cycles.
   always_comb begin
      state_nxt   = state;
      tgt_x_nxt   = tgt_x;
      tgt_y_nxt   = tgt_y;
      xpos_nxt    = player_xpos;
      ypos_nxt    = player_ypos;
      adr_nxt     = map_adr;
      blocked_nxt = 1'b0;
      timer_nxt   = timer;
      wcnt_nxt    = wcnt;
      case (state)
         IDLE: begin
            if (key_dir) begin
               if ((cand_x == player_xpos) && (cand_y == player_ypos)) begin
                  blocked_nxt = 1'b1;
                  timer_nxt   = '0;
                  state_nxt   = HOLD;
               end else begin
                  tgt_x_nxt = cand_x;
                  tgt_y_nxt = cand_y;
                  adr_nxt   = {MAP_YAW'(sh_y), MAP_XAW'(sh_x)};
                  wcnt_nxt  = '0;
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (wcnt == WCNT_LAST) begin
               wcnt_nxt  = '0;
               state_nxt = CHECK;
            end else begin
               wcnt_nxt = wcnt + WCNT_W'(1);
            end
         end
         CHECK: begin
            if (map_pixel == WALL_RGB) begin
               blocked_nxt = 1'b1;
            end else begin
               xpos_nxt = tgt_x;
               ypos_nxt = tgt_y;
            end
            timer_nxt = TMR_ONE;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (timer >= TMR_LAST) begin
               timer_nxt = '0;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer + TMR_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         player_xpos <= X_W'(X_INIT);
         player_ypos <= Y_W'(Y_INIT);
         tgt_x       <= X_W'(X_INIT);
         tgt_y       <= Y_W'(Y_INIT);
         map_adr     <= '0;
         blocked     <= 1'b0;
         moving      <= 1'b0;
         timer       <= '0;
         wcnt        <= '0;
      end else begin
         player_xpos <= xpos_nxt;
         player_ypos <= ypos_nxt;
         tgt_x       <= tgt_x_nxt;
         tgt_y       <= tgt_y_nxt;
         map_adr     <= adr_nxt;
         blocked     <= blocked_nxt;
         moving      <= (state_nxt != IDLE);
         timer       <= timer_nxt;
         wcnt        <= wcnt_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed bench for player_motion_ctrl with a queue of expected step results.
// Honours PLAYER_WRAP_EN when computing expected edge behaviour. Rev 1.0
`default_nettype none

module tb_player_motion_ctrl;

   localparam int ST = 4;
   localparam logic [3:0] K_R    = 4'hD;
   localparam logic [3:0] K_L    = 4'hA;
   localparam logic [3:0] K_D    = 4'h5;
   localparam logic [3:0] K_U    = 4'hE;
   localparam logic [3:0] K_NONE = 4'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  key = 4'h0;
   logic [11:0] map_pixel;
   logic [13:0] map_adr;
   logic [9:0]  xpos, ypos;
   logic        moving, blocked;
   bit          wall_on = 1'b0;

   typedef struct {
      int x;
      int y;
      int adr;
      bit blk;
      bit probe;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   mx = 0, my = 0, madr = 0;

   player_motion_ctrl #(
      .STEP_TICKS (ST),
      .MAP_LAT    (1),
      .STEP       (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key         (key),
      .map_pixel   (map_pixel),
      .map_adr     (map_adr),
      .player_xpos (xpos),
      .player_ypos (ypos),
      .moving      (moving),
      .blocked     (blocked)
   );

   always #5 clk = ~clk;

   // One-cycle synchronous map ROM: either all wall or all free.
   always @(posedge clk) map_pixel <= wall_on ? 12'h000 : 12'hFFF;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_target(input logic [3:0] k, output int tx, output int ty);
      tx = mx;
      ty = my;
      case (k)
         K_R: tx = mx + 1;
         K_L: tx = mx - 1;
         K_D: ty = my + 1;
         K_U: ty = my - 1;
         default: ;
      endcase
`ifdef PLAYER_WRAP_EN
      if (tx > 639) tx = tx - 640;
      if (tx < 0)   tx = tx + 640;
      if (ty > 479) ty = ty - 480;
      if (ty < 0)   ty = ty + 480;
`else
      if (tx > 639) tx = 639;
      if (tx < 0)   tx = 0;
      if (ty > 479) ty = 479;
      if (ty < 0)   ty = 0;
`endif
   endtask

   function automatic int adr_of(input int tx, input int ty);
      return (((ty >> 2) & 63) << 8) | ((tx >> 2) & 255);
   endfunction

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (moving === 1'b1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic do_step(input string tag, input logic [3:0] k, input bit wall);
      int   tx, ty, cnt;
      exp_t e;
      model_target(k, tx, ty);
      e.probe = !(tx == mx && ty == my);
      e.adr   = e.probe ? adr_of(tx, ty) : madr;
      e.blk   = !e.probe || wall;
      e.x     = (e.probe && !wall) ? tx : mx;
      e.y     = (e.probe && !wall) ? ty : my;
      sb.push_back(e);
      wall_on = wall;
      key     = k;
      @(posedge clk);
      @(negedge clk);
      key = K_NONE;
      e = sb.pop_front();
      chk({tag, "_adr"}, map_adr, e.adr);
      chk({tag, "_moving"}, moving, 1);
      if (e.probe) begin
         chk({tag, "_blk_wait"}, blocked, 0);
         @(negedge clk);
         @(negedge clk);
         chk({tag, "_x_commit"}, xpos, e.x);
         chk({tag, "_y_commit"}, ypos, e.y);
         chk({tag, "_blk_commit"}, blocked, e.blk);
      end else begin
         chk({tag, "_blk_edge"}, blocked, 1);
         chk({tag, "_x_edge"}, xpos, mx);
      end
      @(negedge clk);
      chk({tag, "_blk_pulse_end"}, blocked, 0);
      wait_idle(cnt);
      chk({tag, "_hold_len"}, cnt + 1, e.probe ? ST - 1 : ST);
      chk({tag, "_x_final"}, xpos, e.x);
      chk({tag, "_y_final"}, ypos, e.y);
      mx   = e.x;
      my   = e.y;
      madr = e.adr;
   endtask

   initial begin
      int   cnt;
      exp_t e;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_x", xpos, 0);
      chk("rst_y", ypos, 0);
      chk("rst_adr", map_adr, 0);
      chk("rst_moving", moving, 0);
      chk("rst_blocked", blocked, 0);
      rst_n = 1'b1;

      // Non-direction code keeps the FSM idle
      key = 4'h3;
      repeat (3) @(negedge clk);
      chk("nokey_moving", moving, 0);
      chk("nokey_adr", map_adr, 0);
      key = K_NONE;

      // Walk to (8,4), then the RIGHT probe at (9,4) and back
      for (int i = 0; i < 8; i++) do_step("walk_r", K_R, 1'b0);
      for (int i = 0; i < 4; i++) do_step("walk_d", K_D, 1'b0);
      do_step("right_free", K_R, 1'b0);
      chk("right_adr_1_2", map_adr, (1 << 8) | 2);
      do_step("left_back", K_L, 1'b0);
      do_step("down_wall", K_D, 1'b1);
      chk("down_wall_y", ypos, 4);

      // Held UP from y=10 for 30 cycles: five steps
      for (int i = 0; i < 6; i++) do_step("walk_d2", K_D, 1'b0);
      e.x = mx; e.y = my - 5; e.adr = adr_of(mx, my - 5); e.blk = 1'b0; e.probe = 1'b1;
      sb.push_back(e);
      key = K_U;
      repeat (30) @(posedge clk);
      @(negedge clk);
      key = K_NONE;
      wait_idle(cnt);
      e = sb.pop_front();
      chk("held_up_y", ypos, e.y);
      chk("held_up_x", xpos, e.x);
      chk("held_up_adr", map_adr, e.adr);
      mx = e.x; my = e.y; madr = e.adr;

      // Key switched to RIGHT after the UP is taken: only acted on back in IDLE
      key = K_U;
      @(posedge clk);
      @(negedge clk);
      key = K_R;
      @(negedge clk);
      @(negedge clk);
      chk("toggle_y", ypos, my - 1);
      chk("toggle_x_hold", xpos, mx);
      @(negedge clk);
      @(negedge clk);
      chk("toggle_moving_e4", moving, 1);
      chk("toggle_x_e4", xpos, mx);
      @(negedge clk);
      chk("toggle_idle_e5", moving, 0);
      @(negedge clk);
      chk("toggle_resample", moving, 1);
      key = K_NONE;
      @(negedge clk);
      @(negedge clk);
      chk("toggle_x_after", xpos, mx + 1);
      wait_idle(cnt);
      mx = mx + 1; my = my - 1; madr = adr_of(mx, my);
      chk("toggle_adr", map_adr, madr);

      // Reset in the middle of HOLD acts without a clock
      key = K_D;
      @(posedge clk);
      @(negedge clk);
      key = K_NONE;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_y", ypos, my + 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_x", xpos, 0);
      chk("mid_rst_y", ypos, 0);
      chk("mid_rst_adr", map_adr, 0);
      chk("mid_rst_moving", moving, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mx = 0; my = 0; madr = 0;

      // Edge moves at the origin
      do_step("left_edge", K_L, 1'b0);
      do_step("up_edge", K_U, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
